instr_fetch: RTL and testbench

Instruction fetch sequencer sitting directly downstream of the program counter. It samples the current PC, runs a read handshake against instruction memory, and latches the returned word into an instruction register with its address. It presents the instruction to decode through a valid/take handshake and pulses the PC enable once per completed fetch. It also handles branch flushes and memory timeouts.

---
 rtl/instr_fetch_pkg.sv | 35 +++
 rtl/instr_fetch_reg32.sv | 31 +++
 rtl/instr_fetch_timer.sv | 44 ++++
 rtl/instr_fetch.sv | 168 ++++++++++++++++
 tb/tb_instr_fetch.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
// Shared constants for the instruction fetch sequencer:
//   - 3-bit state encodings and the matching enum type
//   - PC_INCREMENT, the step applied by the PC block on each oPCEn pulse
//   - a small helper that identifies the states holding a memory request
// No ports (package).
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_FULL  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  // Step the PC block applies when oPCEn pulses (one 32-bit instruction).
  localparam logic [31:0] PC_INCREMENT = 32'd4;

  localparam int unsigned TIMER_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_REQ   = ST_REQ,
    S_FULL  = ST_FULL,
    S_DRAIN = ST_DRAIN,
    S_FAULT = ST_FAULT
  } fetch_state_t;

  // States in which a read is outstanding towards instruction memory.
  function automatic logic is_mem_state(input fetch_state_t s);
    return (s == S_REQ) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/instr_fetch_reg32.sv
// ---------------------------------------------------------------------------
// reg32
// 32-bit register with load enable and asynchronous active-high reset to 0.
// Ports:
//   clk  in   1   clock
//   rst  in   1   asynchronous active-high reset
//   en   in   1   load enable
//   d    in  32   data in
//   q    out 32   registered data
// ---------------------------------------------------------------------------
module reg32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= 32'd0;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/instr_fetch_timer.sv
// ---------------------------------------------------------------------------
// fetch_timer
// Wait-cycle counter for the memory handshake. Counts enabled cycles since
// the last clear and flags expiry once the count equals LIMIT. LIMIT = 0
// disables expiry entirely.
// Parameters:
//   LIMIT    16-bit expiry threshold (0 = never expires)
// Ports:
//   clk      in  1   clock
//   rst      in  1   asynchronous active-high reset
//   clr      in  1   synchronous clear (wins over en)
//   en       in  1   count this cycle
//   expired  out 1   count has reached LIMIT
// ---------------------------------------------------------------------------
module fetch_timer
  import instr_fetch_pkg::*;
#(
  parameter logic [TIMER_W-1:0] LIMIT = 16'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TIMER_W-1:0] count_reg;
  logic               at_limit;

  assign at_limit = (count_reg == LIMIT);
  assign expired  = (LIMIT != '0) && at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && !expired) begin
      // Hold at the limit once expired so the flag cannot wrap away.
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch sequencer between the PC block and decode. Samples the
// PC, runs a read handshake with instruction memory, captures the returned
// word with its address, and hands it to decode via a valid/take handshake.
// A one-cycle oPCEn pulse advances the PC for every completed fetch. Branch
// flushes discard in-flight or held instructions; a memory that never
// answers drives the block into a sticky fault.
// Parameters:
//   TIMEOUT    max wait cycles for iMemReady (0 disables the timeout)
// Ports:
//   iClk       in   1   clock
//   iRst       in   1   asynchronous active-high reset
//   iPC        in  32   current PC
//   iFlush     in   1   PC is being redirected this cycle
//   oPCEn      out  1   advance-PC pulse (combinational, in REQ only)
//   oMemAddr   out 32   fetch address
//   oMemRead   out  1   memory read request
//   iMemReady  in   1   memory data valid
//   iMemData   in  32   instruction word from memory
//   oIR        out 32   instruction register
//   oIRPC      out 32   address of the instruction in oIR
//   oIRValid   out  1   oIR/oIRPC valid for decode
//   iIRTake    in   1   decode consumes the instruction
//   oFetchErr  out  1   sticky memory-timeout fault
// ---------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [TIMER_W-1:0] TIMEOUT = 16'd255
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iPC,
  input  logic        iFlush,
  output logic        oPCEn,
  output logic [31:0] oMemAddr,
  output logic        oMemRead,
  input  logic        iMemReady,
  input  logic [31:0] iMemData,
  output logic [31:0] oIR,
  output logic [31:0] oIRPC,
  output logic        oIRValid,
  input  logic        iIRTake,
  output logic        oFetchErr
);

  fetch_state_t state_reg;
  fetch_state_t state_next;
  logic [31:0]  addr_reg;
  logic         load_ir;
  logic         timer_clr;
  logic         timer_en;
  logic         timer_expired;
  logic [31:0]  ir_q;
  logic [31:0]  irpc_q;

  // -------------------------------------------------------------------------
  // Next-state decode. Timeout is checked first so a late ready in the
  // expiry cycle cannot complete a fetch the block has already given up on.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    load_ir    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // With a flush pending iPC is stale, so wait for the reload.
        if (!iFlush) begin
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (timer_expired) begin
          state_next = S_FAULT;
        end else if (iMemReady) begin
          if (!iFlush) begin
            load_ir    = 1'b1;
            state_next = S_FULL;
          end else begin
            state_next = S_IDLE;
          end
        end else if (iFlush) begin
          // The read cannot be withdrawn; keep it up until memory answers.
          state_next = S_DRAIN;
        end
      end
      S_FULL: begin
        if (iFlush || iIRTake) begin
          state_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (timer_expired) begin
          state_next = S_FAULT;
        end else if (iMemReady) begin
          state_next = S_IDLE;
        end
      end
      S_FAULT: begin
        state_next = S_FAULT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Clear the wait counter on every entry into a request-holding state,
  // including the REQ -> DRAIN hop.
  assign timer_clr = is_mem_state(state_next) && (state_next != state_reg);
  assign timer_en  = is_mem_state(state_reg) && !iMemReady;

  // -------------------------------------------------------------------------
  // State and fetch-address registers
  // -------------------------------------------------------------------------
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_reg <= S_IDLE;
      addr_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == S_IDLE) && !iFlush) begin
        addr_reg <= iPC;
      end
    end
  end

  fetch_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk     (iClk),
    .rst     (iRst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Instruction word and its address, captured together on a completed read.
  reg32 u_ir (
    .clk (iClk),
    .rst (iRst),
    .en  (load_ir),
    .d   (iMemData),
    .q   (ir_q)
  );

  reg32 u_irpc (
    .clk (iClk),
    .rst (iRst),
    .en  (load_ir),
    .d   (addr_reg),
    .q   (irpc_q)
  );

  // -------------------------------------------------------------------------
  // Output decode. Everything except oPCEn is a function of registers only,
  // so the asynchronous reset clears the outputs immediately. Data outputs
  // are forced to zero outside the states in which they are meaningful.
  // -------------------------------------------------------------------------
  assign oPCEn     = load_ir;
  assign oMemRead  = is_mem_state(state_reg);
  assign oMemAddr  = oMemRead ? addr_reg : 32'd0;
  assign oIRValid  = (state_reg == S_FULL);
  assign oIR       = oIRValid ? ir_q : 32'd0;
  assign oIRPC     = oIRValid ? irpc_q : 32'd0;
  assign oFetchErr = (state_reg == S_FAULT);

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. A transaction-level model tracks what the
// fetch unit must be doing (request outstanding, held instruction, fault)
// and is compared against the DUT on every falling edge. A simple PC block
// in the bench advances on oPCEn and reloads on iFlush. Directed sequences
// add literal expectations that pin the model.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [15:0] TO = 16'd4;

  logic        iClk      = 1'b0;
  logic        iRst      = 1'b1;
  logic [31:0] iPC       = 32'd0;
  logic        iFlush    = 1'b0;
  logic        iMemReady = 1'b0;
  logic [31:0] iMemData  = 32'd0;
  logic        iIRTake   = 1'b0;
  logic        oPCEn;
  logic [31:0] oMemAddr;
  logic        oMemRead;
  logic [31:0] oIR;
  logic [31:0] oIRPC;
  logic        oIRValid;
  logic        oFetchErr;

  int total = 0;
  int bad   = 0;

  always #5 iClk = ~iClk;

  instr_fetch #(.TIMEOUT(TO)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iPC       (iPC),
    .iFlush    (iFlush),
    .oPCEn     (oPCEn),
    .oMemAddr  (oMemAddr),
    .oMemRead  (oMemRead),
    .iMemReady (iMemReady),
    .iMemData  (iMemData),
    .oIR       (oIR),
    .oIRPC     (oIRPC),
    .oIRValid  (oIRValid),
    .iIRTake   (iIRTake),
    .oFetchErr (oFetchErr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment PC block.
  logic [31:0] flush_pc = 32'd0;
  always @(posedge iClk or posedge iRst) begin
    if (iRst)        iPC <= 32'd0;
    else if (iFlush) iPC <= flush_pc;
    else if (oPCEn)  iPC <= iPC + 32'd4;
  end

  // ---------------- transaction-level model ----------------
  bit          m_fault = 0;   // stuck after a memory timeout
  bit          m_req   = 0;   // a read is outstanding
  bit          m_drop  = 0;   // outstanding read's data will be discarded
  bit          m_have  = 0;   // an instruction is waiting for decode
  logic [31:0] m_addr  = 0;
  logic [31:0] m_ir    = 0;
  logic [31:0] m_irpc  = 0;
  int          m_wait  = 0;   // wait cycles since the read (re)started

  function automatic bit m_hit();
    return (TO != 0) && (m_wait == int'(TO));
  endfunction

  always @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      m_fault = 0; m_req = 0; m_drop = 0; m_have = 0;
      m_addr = 0; m_ir = 0; m_irpc = 0; m_wait = 0;
    end else if (m_fault) begin
      m_fault = 1;
    end else if (m_req) begin
      if (m_hit()) begin
        m_fault = 1;
        m_req   = 0;
      end else if (iMemReady) begin
        m_req = 0;
        if (!m_drop && !iFlush) begin
          m_have = 1;
          m_ir   = iMemData;
          m_irpc = m_addr;
        end
      end else begin
        m_wait++;
        if (iFlush && !m_drop) begin
          m_drop = 1;
          m_wait = 0;
        end
      end
    end else if (m_have) begin
      if (iIRTake || iFlush) m_have = 0;
    end else if (!iFlush) begin
      m_req  = 1;
      m_addr = iPC;
      m_drop = 0;
      m_wait = 0;
    end
  end

  // Per-cycle compare plus DUT activity counters for the directed checks.
  int n_pcen = 0, n_read = 0, n_valid = 0;
  always @(negedge iClk) begin
    logic        e_read, e_pcen;
    e_read = !m_fault && m_req;
    e_pcen = e_read && !m_drop && iMemReady && !iFlush && !m_hit();
    check("pcen",    {31'd0, oPCEn},     {31'd0, e_pcen});
    check("memread", {31'd0, oMemRead},  {31'd0, e_read});
    check("memaddr", oMemAddr,           e_read ? m_addr : 32'd0);
    check("irvalid", {31'd0, oIRValid},  {31'd0, m_have});
    check("ir",      oIR,                m_have ? m_ir : 32'd0);
    check("irpc",    oIRPC,              m_have ? m_irpc : 32'd0);
    check("fetcherr",{31'd0, oFetchErr}, {31'd0, m_fault});
    n_pcen  += int'(oPCEn);
    n_read  += int'(oMemRead);
    n_valid += int'(oIRValid);
  end

  task automatic step(input logic f, input logic r, input logic [31:0] d, input logic t);
    iFlush = f; iMemReady = r; iMemData = d; iIRTake = t;
    @(posedge iClk);
    #1;
    $display("step f=%0b r=%0b d=%h t=%0b -> pcen=%0b rd=%0b addr=%h v=%0b ir=%h irpc=%h err=%0b",
             f, r, d, t, oPCEn, oMemRead, oMemAddr, oIRValid, oIR, oIRPC, oFetchErr);
  endtask

  int s_pcen, s_read, s_valid;
  task automatic snap();
    s_pcen = n_pcen; s_read = n_read; s_valid = n_valid;
  endtask

  initial begin
    @(posedge iClk); #1;
    check("rst_read",  {31'd0, oMemRead},  32'd0);
    check("rst_valid", {31'd0, oIRValid},  32'd0);
    check("rst_addr",  oMemAddr,           32'd0);
    check("rst_ir",    oIR,                32'd0);
    check("rst_err",   {31'd0, oFetchErr}, 32'd0);
    @(posedge iClk); #1;
    iRst = 1'b0;

    // 1: zero-wait fetch at PC 0
    snap();
    step(0, 0, 32'h0, 1);                 // IDLE latches PC
    step(0, 1, 32'hDEADBEEF, 1);          // REQ, ready
    check("t1_valid", {31'd0, oIRValid}, 32'd1);
    check("t1_ir",    oIR,   32'hDEADBEEF);
    check("t1_irpc",  oIRPC, 32'h0);
    step(0, 0, 32'h0, 1);                 // FULL, taken
    step(0, 0, 32'h0, 1);                 // IDLE latches PC+4
    check("t1_nextaddr", oMemAddr, 32'h4);
    check("t1_pcen_n",  n_pcen - s_pcen,   32'd1);
    check("t1_valid_n", n_valid - s_valid, 32'd1);

    // 2: three wait states, decode holds off for five cycles
    snap();
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0);
    step(0, 1, 32'hCAFE0004, 0);
    check("t2_ir",   oIR,   32'hCAFE0004);
    check("t2_irpc", oIRPC, 32'h4);
    check("t2_read_n", n_read - s_read, 32'd4);
    for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 0);
    check("t2_held", {31'd0, oIRValid}, 32'd1);
    step(0, 0, 32'h0, 1);
    check("t2_drop", {31'd0, oIRValid}, 32'd0);
    check("t2_valid_n", n_valid - s_valid, 32'd6);
    check("t2_pcen_n",  n_pcen - s_pcen,   32'd1);

    // 3: flush in the second REQ cycle, memory answers two cycles later
    snap();
    step(0, 0, 32'h0, 0);                 // IDLE -> REQ @8
    step(0, 0, 32'h0, 0);                 // REQ cycle 1
    flush_pc = 32'h100;
    step(1, 0, 32'h0, 0);                 // REQ cycle 2, flush -> DRAIN
    check("t3_drain_addr", oMemAddr, 32'h8);
    step(0, 0, 32'h0, 0);                 // DRAIN 1
    step(0, 1, 32'hBAD00000, 0);          // DRAIN 2, data dropped
    check("t3_novalid", {31'd0, oIRValid}, 32'd0);
    check("t3_pcen_n", n_pcen - s_pcen, 32'd0);
    check("t3_read_n", n_read - s_read, 32'd4);
    step(0, 0, 32'h0, 0);                 // IDLE -> REQ @0x100
    check("t3_newaddr", oMemAddr, 32'h100);

    // 4: flush and take together in FULL
    step(0, 1, 32'h11110100, 0);
    check("t4_ir", oIR, 32'h11110100);
    flush_pc = 32'h200;
    step(1, 0, 32'h0, 1);
    check("t4_drop", {31'd0, oIRValid}, 32'd0);
    step(0, 0, 32'h0, 0);
    check("t4_newaddr", oMemAddr, 32'h200);
    step(0, 1, 32'h22220200, 0);
    step(0, 0, 32'h0, 1);

    // Flush while IDLE: stay idle, then fetch from the reloaded PC.
    flush_pc = 32'h300;
    step(1, 0, 32'h0, 0);
    check("idle_flush_read", {31'd0, oMemRead}, 32'd0);
    step(0, 0, 32'h0, 0);
    check("idle_flush_addr", oMemAddr, 32'h300);

    // 6: asynchronous reset in the middle of REQ
    #2 iRst = 1'b1;
    #1;
    check("t6_read", {31'd0, oMemRead}, 32'd0);
    check("t6_addr", oMemAddr, 32'd0);
    iMemReady = 1'b1; iMemData = 32'h0BADF00D;
    @(posedge iClk); #1;
    check("t6_valid", {31'd0, oIRValid}, 32'd0);
    iRst = 1'b0;
    step(0, 0, 32'h0, 0);
    check("t6_restart_addr", oMemAddr, 32'h0);
    check("t6_restart_read", {31'd0, oMemRead}, 32'd1);
    step(0, 1, 32'h33330000, 0);
    check("t6_ir", oIR, 32'h33330000);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0);                 // IDLE -> REQ @4

    // 5: timeout with no memory response
    snap();
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0);
    check("t5_pre_err",  {31'd0, oFetchErr}, 32'd0);
    check("t5_pre_read", {31'd0, oMemRead},  32'd1);
    step(0, 0, 32'h0, 0);
    check("t5_err",  {31'd0, oFetchErr}, 32'd1);
    check("t5_read", {31'd0, oMemRead},  32'd0);
    for (int i = 0; i < 3; i++) step(1, 1, 32'h44444444, 1);
    check("t5_sticky", {31'd0, oFetchErr}, 32'd1);
    check("t5_pcen_n", n_pcen - s_pcen, 32'd0);
    iFlush = 0; iMemReady = 0; iIRTake = 0;
    iRst = 1'b1;
    #1;
    check("t5_clear", {31'd0, oFetchErr}, 32'd0);
    @(posedge iClk); #1;
    iRst = 1'b0;
    step(0, 0, 32'h0, 0);
    check("t5_refetch", {31'd0, oMemRead}, 32'd1);

    @(negedge iClk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
